// File: rtl/cmp_pipe.sv
// Pipelined RV32I branch / set-less-than comparator with valid/ready handshake,
// tag passthrough, flush, illegal-funct3 flagging and a saturating taken counter.
module cmp_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             clr_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_funct3,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef struct packed {
    logic             mode;
    logic             result;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } res_t;

  // Mode 0 decodes the branch funct3 space, mode 1 the SLT/SLTU space.
  function automatic res_t evaluate(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       funct3,
    input logic             mode,
    input logic [TAG_W-1:0] tag
  );
    res_t r;
    logic eq, lt_s, lt_u;
    eq        = (a == b);
    lt_s      = ($signed(a) < $signed(b));
    lt_u      = (a < b);
    r.mode    = mode;
    r.tag     = tag;
    r.result  = 1'b0;
    r.illegal = 1'b0;
    if (!mode) begin
      case (funct3)
        3'b000:  r.result = eq;
        3'b001:  r.result = !eq;
        3'b100:  r.result = lt_s;
        3'b101:  r.result = !lt_s;
        3'b110:  r.result = lt_u;
        3'b111:  r.result = !lt_u;
        default: r.illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b010:  r.result = lt_s;
        3'b011:  r.result = lt_u;
        default: r.illegal = 1'b1;
      endcase
    end
    return r;
  endfunction

  res_t feed;
  logic feed_valid;
  logic out_load;
  res_t out_q;

  // The output stage can take a new entry when empty or when its entry leaves.
  assign out_load = !out_valid || out_ready;

  generate
    if (STAGES == 1) begin : g_one
      assign in_ready   = out_load;
      assign feed_valid = in_valid;
      assign feed       = evaluate(in_a, in_b, in_funct3, in_mode, in_tag);
    end else begin : g_two
      logic             s1_valid;
      logic [WIDTH-1:0] s1_a;
      logic [WIDTH-1:0] s1_b;
      logic [2:0]       s1_funct3;
      logic             s1_mode;
      logic [TAG_W-1:0] s1_tag;

      // s1 advances exactly when it is valid and the output stage loads.
      assign in_ready   = !s1_valid || out_load;
      assign feed_valid = s1_valid;
      assign feed       = evaluate(s1_a, s1_b, s1_funct3, s1_mode, s1_tag);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid  <= 1'b0;
          s1_a      <= '0;
          s1_b      <= '0;
          s1_funct3 <= '0;
          s1_mode   <= 1'b0;
          s1_tag    <= '0;
        end else if (flush) begin
          s1_valid <= 1'b0;
        end else if (in_ready) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_funct3 <= in_funct3;
            s1_mode   <= in_mode;
            s1_tag    <= in_tag;
          end
        end
      end
    end
  endgenerate

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the payload is reset too so out_tag/out_result read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_load) begin
      out_valid <= feed_valid;
      if (feed_valid) out_q <= feed;
    end
  end

  assign out_result  = out_q.result;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

  logic taken;
  assign taken = out_valid && out_ready && !out_q.mode && out_q.result && !out_q.illegal;

  // Clear wins over a simultaneous increment; the counter sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt <= '0;
    end else if (clr_cnt) begin
      taken_cnt <= '0;
    end else if (taken && (taken_cnt != '1)) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: runs the same directed + random suite on a
// 1-stage and a 2-stage instance against a queue-based reference model.
module tb_cmp_pipe;

  localparam int TAG_W   = 5;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic             res;
    logic             ill;
    logic             mode;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, clr_cnt, in_valid, out_ready;
  logic [31:0]      in_a, in_b;
  logic [2:0]       in_funct3;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  bit               sel;
  int               stg;

  logic [1:0]       iv_w, or_w, rdy_w, ov_w, res_w, ill_w;
  logic [TAG_W-1:0] tag_w [2];
  logic [CNT_W-1:0] cnt_w [2];

  assign iv_w[0] = in_valid && !sel;
  assign iv_w[1] = in_valid && sel;
  assign or_w[0] = out_ready && !sel;
  assign or_w[1] = out_ready && sel;

  cmp_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(iv_w[0]), .in_ready(rdy_w[0]), .in_a(in_a), .in_b(in_b),
    .in_funct3(in_funct3), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(ov_w[0]), .out_ready(or_w[0]), .out_result(res_w[0]),
    .out_illegal(ill_w[0]), .out_tag(tag_w[0]), .taken_cnt(cnt_w[0]));

  cmp_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_s2 (
    .clk(clk), .rst(rst), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(iv_w[1]), .in_ready(rdy_w[1]), .in_a(in_a), .in_b(in_b),
    .in_funct3(in_funct3), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(ov_w[1]), .out_ready(or_w[1]), .out_result(res_w[1]),
    .out_illegal(ill_w[1]), .out_tag(tag_w[1]), .taken_cnt(cnt_w[1]));

  logic             cur_rdy, cur_ov, cur_res, cur_ill;
  logic [TAG_W-1:0] cur_tag;
  logic [CNT_W-1:0] cur_cnt;
  always_comb begin
    cur_rdy = rdy_w[sel];
    cur_ov  = ov_w[sel];
    cur_res = res_w[sel];
    cur_ill = ill_w[sel];
    cur_tag = tag_w[sel];
    cur_cnt = cnt_w[sel];
  end

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   cnt_model;
  logic last_acc, last_hs, last_ov, last_rdy, last_res;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference decode written straight from the funct3 tables.
  function automatic exp_t ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f3, input logic m,
                                   input logic [TAG_W-1:0] t);
    exp_t e;
    logic eq, lts, ltu;
    eq     = (a == b);
    lts    = ($signed(a) < $signed(b));
    ltu    = (a < b);
    e.res  = 1'b0;
    e.ill  = 1'b0;
    e.mode = m;
    e.tag  = t;
    case ({m, f3})
      4'b0_000: e.res = eq;
      4'b0_001: e.res = !eq;
      4'b0_100: e.res = lts;
      4'b0_101: e.res = !lts;
      4'b0_110: e.res = ltu;
      4'b0_111: e.res = !ltu;
      4'b1_010: e.res = lts;
      4'b1_011: e.res = ltu;
      default:  e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // One clock: sample at the falling edge, score, update the model, then step.
  task automatic cycle();
    @(negedge clk);
    last_rdy = cur_rdy;
    last_ov  = cur_ov;
    last_res = cur_res;
    last_acc = in_valid && cur_rdy;
    last_hs  = cur_ov && out_ready;
    check("taken_cnt", cur_cnt, cnt_model);
    if (sb.size() == 0) begin
      check("spurious_valid", cur_ov, 0);
    end else if (cur_ov) begin
      check("result", cur_res, sb[0].res);
      check("illegal", cur_ill, sb[0].ill);
      check("tag", cur_tag, sb[0].tag);
    end
    if (clr_cnt) cnt_model = 0;
    else if (last_hs && sb.size() > 0 && !sb[0].mode && sb[0].res && !sb[0].ill
             && cnt_model < CNT_MAX) cnt_model++;
    if (last_hs && sb.size() > 0) void'(sb.pop_front());
    if (last_acc && !flush) sb.push_back(ref_cmp(in_a, in_b, in_funct3, in_mode, in_tag));
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  // NOTE: inputs are driven with blocking assignments 1 time unit after the
  // rising edge so the DUT never races the testbench on a clock edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                      input logic m, input logic [TAG_W-1:0] t);
    int n = 0;
    in_a = a; in_b = b; in_funct3 = f3; in_mode = m; in_tag = t; in_valid = 1'b1;
    do begin cycle(); n++; end while (!last_acc && n < 50);
    if (!last_acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sb.size() > 0 && n < 100) begin cycle(); n++; end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin cycle(); n++; end while (!last_ov && n < 50);
    check("wait_valid", last_ov, 1);
  endtask

  task automatic latency(input string name);
    int k = 0;
    do begin cycle(); k++; end while (!last_ov && k < 20);
    check(name, k, stg);
  endtask

  task automatic run_suite();
    int i, k, acc4;
    int exp_seq[5] = '{1, 2, 3, 3, 3};

    // Reset state.
    in_valid = 0; out_ready = 0; flush = 0; clr_cnt = 0;
    in_a = 0; in_b = 0; in_funct3 = 0; in_mode = 0; in_tag = 0;
    rst = 1'b1;
    #1;
    check("rst_out_valid", cur_ov, 0);
    check("rst_result", cur_res, 0);
    check("rst_illegal", cur_ill, 0);
    check("rst_tag", cur_tag, 0);
    check("rst_cnt", cur_cnt, 0);
    sb.delete();
    cnt_model = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", cur_rdy, 1);

    // Signed vs unsigned on the sign boundary, with latency.
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'd1, 3'b100, 1'b0, 5'd1);
    latency("lat_blt");
    check("blt_neg1_lt_1", last_res, 1);
    send(32'hFFFF_FFFF, 32'd1, 3'b110, 1'b0, 5'd2);
    latency("lat_bltu");
    check("bltu_max_lt_1", last_res, 0);
    drain();

    // Full funct3 sweep with equal operands in both modes.
    for (int m = 0; m < 2; m++)
      for (int f = 0; f < 8; f++)
        send(32'd5, 32'd5, f[2:0], m[0], TAG_W'(m * 8 + f));
    drain();

    // Back-to-back stream under a 4-cycle stall.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    i = 0; k = 0; acc4 = 0;
    while (i < 8 && k < 80) begin
      out_ready = (k >= 4);
      in_a = $urandom; in_b = $urandom; in_funct3 = 3'($urandom_range(0, 7));
      in_mode = 1'b0; in_tag = i[TAG_W-1:0];
      cycle();
      if (k < 4 && last_acc) acc4++;
      if (k == 3) check("stall_in_ready", last_rdy, 0);
      if (last_acc) i++;
      k++;
    end
    check("stall_accepts", acc4, stg);
    check("stream_all", i, 8);
    drain();

    // Flush with ops in flight and an input offered in the flush cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 32'd7; in_b = 32'd7; in_funct3 = 3'b000; in_mode = 1'b0;
    in_tag = 5'd20; cycle();
    in_tag = 5'd21; cycle();
    flush = 1'b1; in_tag = 5'd22; cycle();
    flush = 1'b0; in_tag = 5'd23; out_ready = 1'b1; cycle();
    check("post_flush_accept", last_acc, 1);
    check("post_flush_no_valid", last_ov, 0);
    in_valid = 1'b0;
    drain();
    // Output handshake in the flush cycle still completes and counts.
    out_ready = 1'b0;
    send(32'd3, 32'd3, 3'b000, 1'b0, 5'd9);
    wait_valid();
    flush = 1'b1; out_ready = 1'b1; cycle();
    flush = 1'b0;
    check("flush_hs", last_hs, 1);
    drain();

    // Saturating counter, clear priority, non-counting ops.
    clr_cnt = 1'b1; cycle(); clr_cnt = 1'b0;
    for (int j = 0; j < 5; j++) begin
      send(32'd4, 32'd4, 3'b000, 1'b0, TAG_W'(j));
      drain();
      check("cnt_seq", cur_cnt, exp_seq[j]);
    end
    out_ready = 1'b0;
    send(32'd4, 32'd4, 3'b000, 1'b0, 5'd10);
    wait_valid();
    clr_cnt = 1'b1; out_ready = 1'b1; cycle();
    clr_cnt = 1'b0;
    check("clr_priority", cur_cnt, 0);
    send(32'd4, 32'd4, 3'b000, 1'b0, 5'd11);
    drain();
    send(32'd1, 32'd2, 3'b010, 1'b1, 5'd12);
    send(32'd4, 32'd4, 3'b011, 1'b0, 5'd13);
    drain();
    check("cnt_no_slt_illegal", cur_cnt, 1);

    // Randomised traffic with occasional flush and clear.
    for (int r = 0; r < 300; r++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = $urandom;
      in_b      = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
      if ($urandom_range(0, 7) == 0) in_b[31] = ~in_a[31];
      in_funct3 = 3'($urandom_range(0, 7));
      in_mode   = 1'($urandom_range(0, 1));
      in_tag    = TAG_W'($urandom);
      flush     = ($urandom_range(0, 24) == 0);
      clr_cnt   = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0; clr_cnt = 1'b0;
    drain();

    // Asynchronous reset between edges with work in flight.
    send(32'd6, 32'd6, 3'b000, 1'b0, 5'd14);
    drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 32'd1; in_b = 32'd1; in_funct3 = 3'b000; in_mode = 1'b0; in_tag = 5'd15;
    repeat (3) cycle();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ov", cur_ov, 0);
    check("async_rst_cnt", cur_cnt, 0);
    sb.delete();
    cnt_model = 0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'd2, 32'd9, 3'b100, 1'b0, 5'd16);
    latency("lat_after_rst");
    drain();
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      stg = s + 1;
      run_suite();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cmp_pipe.md
Name: cmp_pipe

Overview:
Parametrised, pipelined successor to the single-cycle branch comparator. Evaluates RV32I branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) and, in set mode, SLT/SLTU conditions on WIDTH-bit operands. Uses a valid/ready handshake with a tag passthrough, flush, illegal-funct3 detection and a saturating taken-branch counter. Sits between the decode/operand-read stage and the execute/PC-select logic, and can be retimed to 1 or 2 stages.

Parameters:
WIDTH, 32, operand width in bits (>=2)
STAGES, 1, pipeline depth: 1 = compare then register; 2 = register operands, compare, register result
TAG_W, 5, width of the opaque tag carried alongside each operation
CNT_W, 16, width of the taken-branch counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  drop all in-flight operations
clr_cnt  in  1  clear taken_cnt
in_valid  in  1  input operation valid
in_ready  out  1  block can accept an input this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_funct3  in  3  RV32I funct3
in_mode  in  1  0 = branch compare, 1 = set-less-than compare
in_tag  in  TAG_W  opaque tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  1  comparison outcome (br_en / slt bit)
out_illegal  out  1  funct3 not legal for in_mode
out_tag  out  TAG_W  tag of the result
taken_cnt  out  CNT_W  count of taken branches delivered

Behaviour:
- Reset (async, rst=1): all stage valid bits = 0, out_valid = 0, out_result = 0, out_illegal = 0, out_tag = 0, taken_cnt = 0. Reset while operations are in flight discards them, with no output.
- Decode, mode 0:
  - 000 eq; 001 ne.
  - 100 signed lt; 101 signed ge.
  - 110 unsigned lt; 111 unsigned ge.
  - 010, 011: result = 0, illegal = 1.
- Decode, mode 1:
  - 010 signed lt; 011 unsigned lt.
  - All other funct3: result = 0, illegal = 1.
- Signed compares treat bit WIDTH-1 as the sign bit.
- Pipeline structure:
  - Each stage holds one entry (valid + payload).
  - A stage loads when it is empty or its entry leaves this cycle.
  - Output stage entry leaves on out_valid & out_ready.
  - in_ready = !s1_valid | s1_advances. A combinational out_ready->in_ready path is permitted.
- Latency and throughput:
  - Input accepted in cycle N appears with out_valid=1 in cycle N+STAGES, assuming no backpressure.
  - Sustained throughput is 1 op/cycle.
- Backpressure: while out_valid & !out_ready, out_result, out_illegal and out_tag hold stable. Upstream stages fill, then in_ready drops. Nothing is lost or duplicated.
- Flush:
  - All valid bits are cleared at the next edge.
  - An input accepted in the flush cycle is discarded.
  - An output handshake in the flush cycle completes normally and counts.
  - in_ready is not gated by flush.
- taken_cnt:
  - Increments on an output handshake with mode 0, result = 1 and illegal = 0.
  - Saturates at 2^CNT_W-1.
  - clr_cnt has priority: clear and increment in the same cycle gives 0.
  - Mode 1 and illegal ops never count.
- Tags pass through unmodified, in order.
- No state machine beyond the per-stage valid bits. The pipeline is strictly in-order.

Test Plan:
1. Mode 0, funct3 100, a=32'hFFFF_FFFF, b=1 -> result 1. Funct3 110 with same operands -> result 0. Both have illegal 0 and out_valid exactly STAGES cycles after accept.
2. Sweep all 8 funct3 in both modes with a=b=5 -> mode 0: 000/101/111 give 1; 001/100/110 give 0; 010/011 give illegal=1, result=0. Mode 1: 010/011 give 0; the other six give illegal.
3. Stream 8 back-to-back ops, tags 0..7, out_ready held 0 for 4 cycles then 1 -> in_ready drops once STAGES entries are held. Outputs hold stable during the stall. Tags 0..7 emerge in order, none lost.
4. Assert flush with 2 ops in flight and a new input accepted the same cycle -> no out_valid the next cycle and none of those tags ever appear. An op accepted one cycle after flush appears normally.
5. CNT_W=2: deliver 5 taken beqs -> taken_cnt reads 1,2,3,3,3. Then clr_cnt together with a taken handshake -> 0. Taken slt and illegal ops leave the count unchanged.
6. Assert rst asynchronously mid-stream, between clock edges -> out_valid and taken_cnt go to 0 immediately. After release, the first new op has normal latency.
